// File: rtl/enemy_green_run_animator_if.sv
// ---------------------------------------------------------------------------
// enemy_green_run_animator_if
// Signal bundle between the video timing / game logic (master) and the green
// running-enemy animator (slave).
//   master drives : frame_tick, DrawX, DrawY, enable, hit
//   slave drives  : enemy_x, enemy_y, anim_frame, alive, sprite_on, rom_address
// ---------------------------------------------------------------------------
interface enemy_green_run_animator_if;
    logic        frame_tick;   // one-cycle pulse at start of vertical blank
    logic [9:0]  DrawX;        // current pixel column
    logic [9:0]  DrawY;        // current pixel row
    logic        enable;       // spawn request (IDLE only)
    logic        hit;          // kill request (RUN only)
    logic [9:0]  enemy_x;      // sprite left edge
    logic [9:0]  enemy_y;      // sprite top edge
    logic [2:0]  anim_frame;   // run-cycle frame index
    logic        alive;        // high while running
    logic        sprite_on;    // current pixel inside visible sprite box
    logic [12:0] rom_address;  // sprite-local ROM address

    modport master (
        output frame_tick, DrawX, DrawY, enable, hit,
        input  enemy_x, enemy_y, anim_frame, alive, sprite_on, rom_address
    );

    modport slave (
        input  frame_tick, DrawX, DrawY, enable, hit,
        output enemy_x, enemy_y, anim_frame, alive, sprite_on, rom_address
    );
endinterface

// File: rtl/enemy_green_run_animator.sv
// ---------------------------------------------------------------------------
// enemy_green_run_animator
// Moves one green running enemy leftward once per video frame, steps its
// run-cycle frame, and for every pixel reports whether the beam is inside the
// visible sprite box together with the sprite-local ROM address.
// Ports:
//   vga_clk  - pixel clock (single clock domain)
//   reset_n  - asynchronous active-low reset
//   bus      - slave side of enemy_green_run_animator_if (see that file)
// ---------------------------------------------------------------------------
module enemy_green_run_animator #(
    parameter int unsigned SPRITE_W    = 40,
    parameter int unsigned SPRITE_H    = 66,
    parameter int unsigned NUM_FRAMES  = 5,
    parameter int unsigned FRAME_HOLD  = 6,
    parameter int unsigned SPEED       = 2,
    parameter int unsigned START_X     = 600,
    parameter int unsigned GROUND_Y    = 350,
    parameter int unsigned DYING_TICKS = 30
) (
    input  logic                         vga_clk,
    input  logic                         reset_n,
    enemy_green_run_animator_if.slave    bus
);

    localparam int unsigned HOLD_W = (FRAME_HOLD  > 1) ? $clog2(FRAME_HOLD)  : 1;
    localparam int unsigned DIE_W  = (DYING_TICKS > 1) ? $clog2(DYING_TICKS) : 1;

    localparam logic [9:0]        START_X_C   = 10'(START_X);
    localparam logic [9:0]        GROUND_Y_C  = 10'(GROUND_Y);
    localparam logic [9:0]        SPEED_C     = 10'(SPEED);
    localparam logic [2:0]        LAST_FRAME  = 3'(NUM_FRAMES - 1);
    localparam logic [HOLD_W-1:0] LAST_HOLD   = HOLD_W'(FRAME_HOLD - 1);
    localparam logic [DIE_W-1:0]  LAST_DIE    = DIE_W'(DYING_TICKS - 1);
    localparam logic [10:0]       SPRITE_W_11 = 11'(SPRITE_W);
    localparam logic [10:0]       SPRITE_H_11 = 11'(SPRITE_H);
    localparam logic [12:0]       SPRITE_W_13 = 13'(SPRITE_W);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DYING = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [9:0]          x_q, x_d;
    logic [9:0]          y_q;
    logic [2:0]          frame_q, frame_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [DIE_W-1:0]    die_q, die_d;
    logic                alive_q;
    logic                on_q, on_d;
    logic [12:0]         addr_q, addr_d;

    // pixel-path intermediates
    logic [10:0]         dx_s, dy_s, ex_s, ey_s, lx_s, ly_s;
    logic                inside_s, visible_s;

    // Game-state FSM next-state logic; everything moves only on frame_tick.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        frame_d = frame_q;
        hold_d  = hold_q;
        die_d   = die_q;
        if (bus.frame_tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.enable) begin
                        state_d = ST_RUN;
                        x_d     = START_X_C;
                        frame_d = 3'd0;
                        hold_d  = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (bus.hit) begin
                        // position and frame freeze for the death blink
                        state_d = ST_DYING;
                        die_d   = '0;
                    end else if (x_q < SPEED_C) begin
                        // walked off the left edge
                        state_d = ST_IDLE;
                        x_d     = START_X_C;
                        frame_d = 3'd0;
                        hold_d  = '0;
                    end else begin
                        x_d = x_q - SPEED_C;
                        if (hold_q == LAST_HOLD) begin
                            hold_d  = '0;
                            frame_d = (frame_q == LAST_FRAME) ? 3'd0 : frame_q + 3'd1;
                        end else begin
                            hold_d = hold_q + HOLD_W'(1);
                        end
                    end
                end
                ST_DYING: begin
                    if (die_q == LAST_DIE) begin
                        state_d = ST_IDLE;
                        x_d     = START_X_C;
                        frame_d = 3'd0;
                        hold_d  = '0;
                    end else begin
                        die_d = die_q + DIE_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    x_d     = START_X_C;
                    frame_d = 3'd0;
                    hold_d  = '0;
                    die_d   = '0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Pixel hit test against the pre-update position; done in 11 bits so
    // enemy_x + SPRITE_W cannot wrap.
    always_comb begin
        dx_s      = {1'b0, bus.DrawX};
        dy_s      = {1'b0, bus.DrawY};
        ex_s      = {1'b0, x_q};
        ey_s      = {1'b0, y_q};
        lx_s      = dx_s - ex_s;
        ly_s      = dy_s - ey_s;
        inside_s  = (dx_s >= ex_s) && (dx_s < (ex_s + SPRITE_W_11)) &&
                    (dy_s >= ey_s) && (dy_s < (ey_s + SPRITE_H_11));
        // DYING blinks: shown on even die counts only
        visible_s = (state_q == ST_RUN) || ((state_q == ST_DYING) && !die_q[0]);
        on_d      = inside_s && visible_s;
        if (on_d) begin
            addr_d = (13'(ly_s) * SPRITE_W_13) + 13'(lx_s);
        end else begin
            addr_d = 13'd0;
        end
    end

    // State, position, animation and pixel-output registers.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            x_q     <= START_X_C;
            y_q     <= GROUND_Y_C;
            frame_q <= 3'd0;
            hold_q  <= '0;
            die_q   <= '0;
            alive_q <= 1'b0;
            on_q    <= 1'b0;
            addr_q  <= 13'd0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= GROUND_Y_C;
            frame_q <= frame_d;
            hold_q  <= hold_d;
            die_q   <= die_d;
            alive_q <= (state_d == ST_RUN);
            on_q    <= on_d;
            addr_q  <= addr_d;
        end
    end

    assign bus.enemy_x     = x_q;
    assign bus.enemy_y     = y_q;
    assign bus.anim_frame  = frame_q;
    assign bus.alive       = alive_q;
    assign bus.sprite_on   = on_q;
    assign bus.rom_address = addr_q;

endmodule

// File: tb/tb_enemy_green_run_animator.sv
// ---------------------------------------------------------------------------
// tb_enemy_green_run_animator
// Directed bench: a small behavioural model of the enemy tracks state,
// position and animation; pixel probes push their expected result to a
// scoreboard queue and pop it when the registered pixel output appears.
// ---------------------------------------------------------------------------
module tb_enemy_green_run_animator;

    logic vga_clk = 1'b0;
    logic reset_n;

    always #5 vga_clk = ~vga_clk;

    enemy_green_run_animator_if bus ();

    enemy_green_run_animator dut (
        .vga_clk (vga_clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    typedef struct packed {
        logic        on;
        logic [12:0] addr;
    } pix_t;

    pix_t sb[$];

    // model: 0 idle, 1 run, 2 dying
    int m_state, m_x, m_frame, m_hold, m_die;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_x = 600; m_frame = 0; m_hold = 0; m_die = 0;
    endtask

    task automatic check_state();
        chk("enemy_x",    32'(bus.enemy_x),    m_x);
        chk("enemy_y",    32'(bus.enemy_y),    350);
        chk("anim_frame", 32'(bus.anim_frame), m_frame);
        chk("alive",      32'(bus.alive),      (m_state == 1) ? 1 : 0);
    endtask

    // One frame_tick cycle; called at posedge+1, returns at posedge+1.
    task automatic tick(input logic en, input logic h);
        bus.frame_tick = 1'b1;
        bus.enable     = en;
        bus.hit        = h;
        case (m_state)
            0: if (en) begin m_state = 1; m_x = 600; m_frame = 0; m_hold = 0; end
            1: begin
                if (h) begin
                    m_state = 2; m_die = 0;
                end else if (m_x < 2) begin
                    m_state = 0; m_x = 600; m_frame = 0; m_hold = 0;
                end else begin
                    m_x = m_x - 2;
                    if (m_hold == 5) begin
                        m_hold = 0; m_frame = (m_frame + 1) % 5;
                    end else begin
                        m_hold = m_hold + 1;
                    end
                end
            end
            2: begin
                if (m_die == 29) begin
                    m_state = 0; m_x = 600; m_frame = 0; m_hold = 0;
                end else begin
                    m_die = m_die + 1;
                end
            end
            default: m_state = 0;
        endcase
        @(posedge vga_clk); #1;
        bus.frame_tick = 1'b0;
        bus.enable     = 1'b0;
        bus.hit        = 1'b0;
        check_state();
    endtask

    // One pixel probe; expected result goes through the scoreboard.
    task automatic pix(input int x, input int y);
        pix_t e;
        bit   vis, ins;
        bus.DrawX = 10'(x);
        bus.DrawY = 10'(y);
        vis = (m_state == 1) || ((m_state == 2) && (m_die % 2 == 0));
        ins = (x >= m_x) && (x < m_x + 40) && (y >= 350) && (y < 350 + 66);
        e.on   = vis && ins;
        e.addr = e.on ? 13'((y - 350) * 40 + (x - m_x)) : 13'd0;
        sb.push_back(e);
        @(posedge vga_clk); #1;
        e = sb.pop_front();
        chk("sprite_on",   32'(bus.sprite_on),   32'(e.on));
        chk("rom_address", 32'(bus.rom_address), 32'(e.addr));
    endtask

    initial begin
        reset_n        = 1'b0;
        bus.frame_tick = 1'b0;
        bus.enable     = 1'b0;
        bus.hit        = 1'b0;
        bus.DrawX      = 10'd0;
        bus.DrawY      = 10'd0;
        model_reset();

        // reset values
        repeat (2) @(posedge vga_clk);
        #1;
        check_state();
        chk("rst_sprite_on", 32'(bus.sprite_on),   0);
        chk("rst_rom_addr",  32'(bus.rom_address), 0);

        reset_n = 1'b1;
        @(posedge vga_clk); #1;

        // idle: invisible, hit ignored
        for (int i = 0; i < 3; i++) begin
            pix(600, 350);
            pix(620, 380);
            tick(1'b0, 1'b1);
        end

        // spawn
        tick(1'b1, 1'b0);
        chk("spawn_x", 32'(bus.enemy_x), 600);
        pix(600, 350);

        repeat (6) tick(1'b0, 1'b0);
        chk("x_after6",     32'(bus.enemy_x),    588);
        chk("frame_after6", 32'(bus.anim_frame), 1);
        pix(588, 350);
        pix(627, 415);
        chk("addr_max", 32'(bus.rom_address), 2639);
        pix(628, 415);
        pix(587, 350);
        pix(600, 416);
        pix(627, 349);

        repeat (24) tick(1'b0, 1'b0);
        chk("frame_wrap", 32'(bus.anim_frame), 0);
        chk("x_after30",  32'(bus.enemy_x),    540);

        repeat (70) tick(1'b0, 1'b0);
        chk("x_before_hit", 32'(bus.enemy_x), 400);

        // kill and blink, enable/hit ignored while dying
        tick(1'b0, 1'b1);
        chk("hit_alive", 32'(bus.alive),   0);
        chk("hit_x",     32'(bus.enemy_x), 400);
        for (int i = 1; i <= 30; i++) begin
            pix(410, 360);
            tick(1'(i % 2), 1'(i % 3 == 0));
        end
        chk("die_done_x", 32'(bus.enemy_x), 600);
        pix(600, 350);

        // run off the left edge
        tick(1'b1, 1'b0);
        repeat (300) tick(1'b0, 1'b0);
        chk("x_at_edge", 32'(bus.enemy_x), 0);
        pix(0, 350);
        pix(39, 415);
        tick(1'b0, 1'b0);
        chk("edge_exit_x", 32'(bus.enemy_x), 600);
        pix(600, 350);

        // reset in the middle of DYING
        tick(1'b1, 1'b0);
        repeat (3) tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        pix(594, 350);
        #3 reset_n = 1'b0;
        #1;
        model_reset();
        check_state();
        chk("midrst_sprite_on", 32'(bus.sprite_on),   0);
        chk("midrst_rom_addr",  32'(bus.rom_address), 0);
        #2 reset_n = 1'b1;
        sb.delete();
        @(posedge vga_clk); #1;
        tick(1'b0, 1'b1);
        pix(600, 350);
        tick(1'b1, 1'b0);
        chk("respawn_alive", 32'(bus.alive), 1);
        pix(639, 415);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
